tb_stim_sequencer: RTL and testbench

//  Clocked stimulus/check engine for board-level simulation of thinpad_top.
//  - Replaces a single fixed reset pulse and one static dip_sw value.
//  - Holds the DUT in reset, then steps through NUM_STEPS switch settings.
//  - Checks the masked leds against an expected value for each step.
//  - Reports pass/fail, with the failing step index and the leds value that failed.

---
 rtl/tb_stim_pkg.sv | 31 +++
 rtl/tb_stim_sequencer_match.sv | 40 ++++
 rtl/tb_stim_sequencer.sv | 128 ++++++++++++
 tb/tb_tb_stim_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_stim_pkg.sv
// Shared types and the default step table for the board-level stimulus sequencer.
// Consumers may define TB_STIM_STEP_RESET_EN to re-reset the DUT before every step.
package tb_stim_pkg;

    localparam int unsigned TO_W_MAX = 32;

    typedef struct packed {
        logic [31:0]         dip;
        logic [15:0]         exp;
        logic [15:0]         mask;
        logic [TO_W_MAX-1:0] timeout;
    } step_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_APPLY,
        S_WAIT,
        S_DONE,
        S_FAIL
    } state_e;

    // Step 1 has an empty mask (always matches); step 2 checks only the low byte.
    localparam step_t [3:0] DEFAULT_STEPS = {
        step_t'{dip: 32'h0000_0008, exp: 16'h0008, mask: 16'hFFFF, timeout: 32'd40},
        step_t'{dip: 32'h0000_0004, exp: 16'h0004, mask: 16'h00FF, timeout: 32'd100},
        step_t'{dip: 32'h0000_0002, exp: 16'h0002, mask: 16'h0000, timeout: 32'd100},
        step_t'{dip: 32'h0000_0001, exp: 16'h0001, mask: 16'hFFFF, timeout: 32'd100}
    };

endpackage

// File: rtl/tb_stim_sequencer_match.sv
// Counts consecutive cycles where the masked leds equal the expected value and
// pulses stable_c on the cycle that completes a run of STABLE_CYC matches.
module tb_led_match_counter #(
    parameter int unsigned LED_W      = 16,
    parameter int unsigned STABLE_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [LED_W-1:0] leds,
    input  logic [LED_W-1:0] exp,
    input  logic [LED_W-1:0] mask,
    output logic             stable_c
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);

    logic [CNT_W-1:0] stab_cnt;
    logic             match_c;

    assign match_c  = ((leds ^ exp) & mask) == '0;
    assign stable_c = en && match_c && (stab_cnt == CNT_W'(STABLE_CYC - 1));

    // Run length of matching cycles; any mismatch restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stab_cnt <= '0;
        end else if (clr) begin
            stab_cnt <= '0;
        end else if (en) begin
            if (!match_c) begin
                stab_cnt <= '0;
            end else if (stab_cnt != CNT_W'(STABLE_CYC)) begin
                stab_cnt <= stab_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tb_stim_sequencer.sv
// Clocked stimulus/check engine: resets the DUT, walks the step table and checks leds.
// Define TB_STIM_STEP_RESET_EN to re-reset the DUT ahead of every step.
module tb_stim_sequencer
    import tb_stim_pkg::*;
#(
    parameter int unsigned DIP_W      = 32,
    parameter int unsigned LED_W      = 16,
    parameter int unsigned NUM_STEPS  = 4,
    parameter int unsigned RST_CYC    = 5,
    parameter int unsigned STABLE_CYC = 3,
    parameter int unsigned TO_W       = 20,
    parameter step_t [NUM_STEPS-1:0] STEPS = DEFAULT_STEPS
) (
    input  logic             clk_50M,
    input  logic             reset_btn,
    input  logic             start,
    output logic             dut_rst,
    output logic [DIP_W-1:0] dip_sw,
    input  logic [LED_W-1:0] leds,
    output logic [7:0]       step_idx,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [LED_W-1:0] fail_leds
);

    localparam int unsigned IDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int unsigned RST_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    state_e          state;
    logic [RST_W-1:0] rst_cnt;
    logic [TO_W-1:0]  to_cnt;
    step_t            cur_step;
    logic             stable_c;
    logic             timed_out_c;
    logic             last_step_c;

    assign cur_step    = STEPS[IDX_W'(step_idx)];
    assign last_step_c = step_idx == 8'(NUM_STEPS - 1);
    assign timed_out_c = (cur_step.timeout != '0) && (to_cnt == TO_W'(cur_step.timeout));

    tb_led_match_counter #(
        .LED_W      (LED_W),
        .STABLE_CYC (STABLE_CYC)
    ) u_match (
        .clk      (clk_50M),
        .rst      (reset_btn),
        .clr      (state == S_APPLY),
        .en       (state == S_WAIT),
        .leds     (leds),
        .exp      (LED_W'(cur_step.exp)),
        .mask     (LED_W'(cur_step.mask)),
        .stable_c (stable_c)
    );

    // Sequencer FSM with registered outputs; DONE/FAIL hold dip_sw, dut_rst and step_idx.
    always_ff @(posedge clk_50M or posedge reset_btn) begin
        if (reset_btn) begin
            state     <= S_IDLE;
            dut_rst   <= 1'b1;
            dip_sw    <= '0;
            step_idx  <= '0;
            busy      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_leds <= '0;
            rst_cnt   <= '0;
            to_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        state    <= S_RESET;
                        rst_cnt  <= '0;
                        step_idx <= '0;
                        pass     <= 1'b0;
                        fail     <= 1'b0;
                        busy     <= 1'b1;
                        dut_rst  <= 1'b1;
                        dip_sw   <= DIP_W'(STEPS[0].dip);
                    end
                end
                S_RESET: begin
                    if (rst_cnt == RST_W'(RST_CYC - 1)) begin
                        state   <= S_APPLY;
                        dut_rst <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
                S_APPLY: begin
                    dip_sw <= DIP_W'(cur_step.dip);
                    to_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    // Stability is checked first so it wins over a coincident timeout.
                    if (stable_c) begin
                        if (last_step_c) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            pass  <= 1'b1;
                        end else begin
                            step_idx <= step_idx + 8'd1;
`ifdef TB_STIM_STEP_RESET_EN
                            state    <= S_RESET;
                            rst_cnt  <= '0;
                            dut_rst  <= 1'b1;
                            dip_sw   <= DIP_W'(STEPS[IDX_W'(step_idx + 8'd1)].dip);
`else
                            state    <= S_APPLY;
`endif
                        end
                    end else if (timed_out_c) begin
                        state     <= S_FAIL;
                        busy      <= 1'b0;
                        fail      <= 1'b1;
                        fail_leds <= leds;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tb_stim_sequencer.sv
// Self-checking bench for tb_stim_sequencer: directed vector table, corner sequences
// and randomized leds traces checked against a cycle-schedule reference model.
module tb_tb_stim_sequencer;
    import tb_stim_pkg::*;

    localparam int RST  = 5;
    localparam int STAB = 3;
`ifdef TB_STIM_STEP_RESET_EN
    localparam int EXTRA     = RST;
    localparam int EXP_FALLS = 4;
`else
    localparam int EXTRA     = 0;
    localparam int EXP_FALLS = 1;
`endif

    logic        clk_50M = 1'b0;
    logic        reset_btn;
    logic        start;
    logic        dut_rst;
    logic [31:0] dip_sw;
    logic [15:0] leds;
    logic [7:0]  step_idx;
    logic        busy, pass, fail;
    logic [15:0] fail_leds;

    logic        follow;
    logic [15:0] leds_drv;
    assign leds = follow ? dip_sw[15:0] : leds_drv;

    tb_stim_sequencer #(
        .DIP_W(32), .LED_W(16), .NUM_STEPS(4), .RST_CYC(RST), .STABLE_CYC(STAB), .TO_W(20)
    ) dut (
        .clk_50M   (clk_50M),
        .reset_btn (reset_btn),
        .start     (start),
        .dut_rst   (dut_rst),
        .dip_sw    (dip_sw),
        .leds      (leds),
        .step_idx  (step_idx),
        .busy      (busy),
        .pass      (pass),
        .fail      (fail),
        .fail_leds (fail_leds)
    );

    always #5 clk_50M = ~clk_50M;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rst_falls = 0;
    logic prev_rst = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk_50M);
        #1;
        cyc++;
        if (prev_rst && !dut_rst) rst_falls++;
        prev_rst = dut_rst;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
    endtask

    function automatic int apply_cyc(input int k);
        return RST + k * (1 + STAB + EXTRA);
    endfunction

    function automatic logic led_ok(input logic [15:0] l, input step_t s);
        return ((l ^ s.exp) & s.mask) == 16'h0;
    endfunction

    // Expected-output records for the reactive pass path (leds = dip_sw[15:0]).
    typedef struct {
        int          c;
        logic        rst;
        logic [31:0] dip;
        logic [7:0]  idx;
        logic        busy;
        logic        pass;
    } vec_t;
    vec_t vecs [8];

    // Reference model: builds the per-cycle leds trace and the expected outcome.
    logic [15:0] trace [$];
    int          exp_end;
    logic        exp_pass;
    int          exp_idx;
    logic [15:0] exp_fleds;

    task automatic build_trial(input int bad_step);
        step_t s;
        logic [15:0] l;
        int run, i;
        logic done;
        trace.delete();
        exp_pass = 1'b1;
        exp_idx  = 3;
        exp_fleds = 16'h0;
        repeat (RST) trace.push_back(16'($urandom));
        for (int k = 0; k < 4 && exp_pass; k++) begin
            s = DEFAULT_STEPS[k];
            if (k > 0) repeat (EXTRA) trace.push_back(16'($urandom));
            trace.push_back(16'($urandom));
            run = 0; i = 0; done = 1'b0;
            while (!done) begin
                if (k == bad_step)
                    l = ((s.exp ^ s.mask) & s.mask) | (16'($urandom) & ~s.mask);
                else if ($urandom_range(0, 7) != 0)
                    l = (s.exp & s.mask) | (16'($urandom) & ~s.mask);
                else
                    l = 16'($urandom);
                trace.push_back(l);
                run = led_ok(l, s) ? run + 1 : 0;
                if (run == STAB) begin
                    done = 1'b1;
                end else if (s.timeout != 0 && i == int'(s.timeout)) begin
                    done = 1'b1;
                    exp_pass = 1'b0;
                    exp_idx = k;
                    exp_fleds = l;
                end
                i++;
            end
        end
        exp_end = trace.size();
    endtask

    initial begin
        int n, got, bad;
        logic [15:0] glitch [6];
        reset_btn = 1'b1;
        start = 1'b0;
        follow = 1'b1;
        leds_drv = 16'h0;

        // Reset state.
        repeat (3) tick();
        chk("rst_dut_rst", 32'(dut_rst), 1);
        chk("rst_dip", dip_sw, 0);
        chk("rst_idx", 32'(step_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_fail", 32'(fail), 0);
        chk("rst_fleds", 32'(fail_leds), 0);
        reset_btn = 1'b0;
        tick();

        // Pass path, table driven.
        vecs[0] = '{0,                  1'b1, 32'd1, 8'd0, 1'b1, 1'b0};
        vecs[1] = '{RST - 1,            1'b1, 32'd1, 8'd0, 1'b1, 1'b0};
        vecs[2] = '{apply_cyc(0),       1'b0, 32'd1, 8'd0, 1'b1, 1'b0};
        vecs[3] = '{apply_cyc(1) + 1,   1'b0, 32'd2, 8'd1, 1'b1, 1'b0};
        vecs[4] = '{apply_cyc(2) + 1,   1'b0, 32'd4, 8'd2, 1'b1, 1'b0};
        vecs[5] = '{apply_cyc(3) + 1,   1'b0, 32'd8, 8'd3, 1'b1, 1'b0};
        vecs[6] = '{apply_cyc(3) + STAB,     1'b0, 32'd8, 8'd3, 1'b1, 1'b0};
        vecs[7] = '{apply_cyc(3) + STAB + 1, 1'b0, 32'd8, 8'd3, 1'b0, 1'b1};
        follow = 1'b1;
        rst_falls = 0;
        do_start();
        for (int v = 0; v < 8; v++) begin
            while (cyc < vecs[v].c) tick();
            chk($sformatf("vec%0d_dut_rst", v), 32'(dut_rst), 32'(vecs[v].rst));
            chk($sformatf("vec%0d_dip", v), dip_sw, vecs[v].dip);
            chk($sformatf("vec%0d_idx", v), 32'(step_idx), 32'(vecs[v].idx));
            chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].busy));
            chk($sformatf("vec%0d_pass", v), 32'(pass), 32'(vecs[v].pass));
        end
        chk("rst_pulses", rst_falls, EXP_FALLS);

        // Glitch: a single mismatch restarts the stability run.
        glitch[0] = 16'h0001; glitch[1] = 16'h0001; glitch[2] = 16'h0000;
        glitch[3] = 16'h0001; glitch[4] = 16'h0001; glitch[5] = 16'h0001;
        follow = 1'b0;
        leds_drv = 16'h0;
        do_start();
        while (cyc < RST + 1) tick();
        for (int i = 0; i < 6; i++) begin
            leds_drv = glitch[i];
            if (i == 5) chk("glitch_hold", 32'(step_idx), 0);
            tick();
        end
        chk("glitch_adv", 32'(step_idx), 1);

        // Asynchronous reset in the middle of step 2.
        follow = 1'b1;
        n = 0;
        while (step_idx != 8'd2 && n < 200) begin tick(); n++; end
        chk("reach_step2_a", 32'(step_idx), 2);
        repeat (2 + EXTRA) tick();
        reset_btn = 1'b1;
        #1;
        chk("midrst_dut_rst", 32'(dut_rst), 1);
        chk("midrst_dip", dip_sw, 0);
        chk("midrst_idx", 32'(step_idx), 0);
        chk("midrst_busy", 32'(busy), 0);
        tick();
        reset_btn = 1'b0;
        tick();
        chk("midrst_idle", 32'(busy), 0);

        // Timeout on step 2 with leds stuck.
        follow = 1'b1;
        do_start();
        n = 0;
        while (step_idx != 8'd2 && n < 200) begin tick(); n++; end
        chk("reach_step2_b", 32'(step_idx), 2);
        follow = 1'b0;
        leds_drv = 16'h1234;
        got = -1;
        for (int d = 0; d < 500; d++) begin
            if (fail || !busy) begin got = d; break; end
            tick();
        end
        chk("tmo_latency", got, 102 + EXTRA);
        chk("tmo_fail", 32'(fail), 1);
        chk("tmo_pass", 32'(pass), 0);
        chk("tmo_fleds", 32'(fail_leds), 32'h1234);
        chk("tmo_idx", 32'(step_idx), 2);
        tick();
        chk("tmo_idx_held", 32'(step_idx), 2);

        // Randomized traces against the reference model; reruns start from DONE/FAIL.
        for (int t = 0; t < 20; t++) begin
            bad = $urandom_range(0, 6);
            build_trial(bad);
            follow = 1'b0;
            leds_drv = trace[0];
            do_start();
            got = -1;
            for (int k = 0; k < 2000; k++) begin
                if (!busy) begin got = cyc; break; end
                leds_drv = (cyc < trace.size()) ? trace[cyc] : 16'h0;
                start = (cyc == 3);
                tick();
            end
            start = 1'b0;
            chk($sformatf("rnd%0d_end", t), got, exp_end);
            chk($sformatf("rnd%0d_pass", t), 32'(pass), 32'(exp_pass));
            chk($sformatf("rnd%0d_fail", t), 32'(fail), 32'(!exp_pass));
            chk($sformatf("rnd%0d_idx", t), 32'(step_idx), exp_idx);
            chk($sformatf("rnd%0d_dip", t), dip_sw, DEFAULT_STEPS[exp_idx].dip);
            if (!exp_pass) chk($sformatf("rnd%0d_fleds", t), 32'(fail_leds), 32'(exp_fleds));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
